// File: rtl/mode_timeout_timer.sv
// Mode-gated seconds timeout with pause/restart, 1 Hz tick, expiry strobe and expiry level.
// Only counts while the game mode is in ACTIVE_MASK; optionally reloads to give a periodic pulse.
module mode_timeout_timer #(
  parameter int unsigned               MODE_W      = 3,
  parameter logic [2**MODE_W-1:0]      ACTIVE_MASK = 8'b0010_0101,
  parameter int unsigned               CLK_HZ      = 50_000_000,
  parameter int unsigned               TIMEOUT_S   = 3,
  parameter int unsigned               SEC_W       = 8,
  parameter bit                        AUTO_RELOAD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MODE_W-1:0] M,
  input  logic              pause,
  input  logic              restart,
  output logic              C,
  output logic              C_pulse,
  output logic              tick_1hz,
  output logic [SEC_W-1:0]  secs_left,
  output logic              running
);

  localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0] SECS_INIT = SEC_W'(TIMEOUT_S);

  if (CLK_HZ < 2) begin : g_bad_clk_hz
    $error("mode_timeout_timer: CLK_HZ must be >= 2");
  end
  if (TIMEOUT_S < 1) begin : g_bad_timeout
    $error("mode_timeout_timer: TIMEOUT_S must be >= 1");
  end
  if ((SEC_W < 32) && (TIMEOUT_S >= (64'd1 << SEC_W))) begin : g_bad_sec_w
    $error("mode_timeout_timer: TIMEOUT_S does not fit in SEC_W bits");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHold,
    StExpired
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEC_W-1:0] secs_q, secs_d;
  logic             c_q, c_d;
  logic             pulse_q, pulse_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;
  logic             active;
  logic             wrap;

  assign active = ACTIVE_MASK[M];
  assign wrap   = (cnt_q == CNT_MAX);

  // Priority: inactive mode, then restart, then per-state counting; pause only picks next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    secs_d  = secs_q;
    c_d     = 1'b0;
    pulse_d = 1'b0;
    tick_d  = 1'b0;

    if (!active) begin
      state_d = StIdle;
      cnt_d   = '0;
      secs_d  = SECS_INIT;
    end else if (restart) begin
      cnt_d   = '0;
      secs_d  = SECS_INIT;
      state_d = pause ? StHold : StRun;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d   = '0;
          secs_d  = SECS_INIT;
          state_d = pause ? StHold : StRun;
        end
        StRun: begin
          state_d = pause ? StHold : StRun;
          if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (secs_q == SEC_W'(1)) begin
              pulse_d = 1'b1;
              c_d     = 1'b1;
              if (AUTO_RELOAD) begin
                secs_d = SECS_INIT;
              end else begin
                secs_d  = '0;
                state_d = StExpired;
              end
            end else begin
              secs_d = secs_q - SEC_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StHold: begin
          if (!pause) state_d = StRun;
        end
        StExpired: begin
          c_d    = 1'b1;
          secs_d = '0;
        end
        default: state_d = StIdle;
      endcase
    end

    running_d = (state_d == StRun);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      secs_q    <= SECS_INIT;
      c_q       <= 1'b0;
      pulse_q   <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      secs_q    <= secs_d;
      c_q       <= c_d;
      pulse_q   <= pulse_d;
      tick_q    <= tick_d;
      running_q <= running_d;
    end
  end

  assign C         = c_q;
  assign C_pulse   = pulse_q;
  assign tick_1hz  = tick_q;
  assign secs_left = secs_q;
  assign running   = running_q;

endmodule

// File: tb/tb_mode_timeout_timer.sv
// Directed bench for mode_timeout_timer: latching instance and auto-reload instance,
// expiry pulses scored against a queue of expected cycle numbers.
module tb_mode_timeout_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, pause0, restart0, c0, cp0, tick0, run0;
  logic [2:0] m0;
  logic [3:0] secs0;
  logic       rst1, pause1, restart1, c1, cp1, tick1, run1;
  logic [2:0] m1;
  logic [3:0] secs1;

  mode_timeout_timer #(
    .CLK_HZ     (4),
    .TIMEOUT_S  (3),
    .SEC_W      (4),
    .AUTO_RELOAD(1'b0)
  ) dut0 (
    .clk      (clk),
    .rst      (rst0),
    .M        (m0),
    .pause    (pause0),
    .restart  (restart0),
    .C        (c0),
    .C_pulse  (cp0),
    .tick_1hz (tick0),
    .secs_left(secs0),
    .running  (run0)
  );

  mode_timeout_timer #(
    .CLK_HZ     (4),
    .TIMEOUT_S  (3),
    .SEC_W      (4),
    .AUTO_RELOAD(1'b1)
  ) dut1 (
    .clk      (clk),
    .rst      (rst1),
    .M        (m1),
    .pause    (pause1),
    .restart  (restart1),
    .C        (c1),
    .C_pulse  (cp1),
    .tick_1hz (tick1),
    .secs_left(secs1),
    .running  (run1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int q0[$];
  int q1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every C_pulse must match the next expected cycle; strobes never repeat.
  logic tick0_prev = 1'b0, cp0_prev = 1'b0, tick1_prev = 1'b0, cp1_prev = 1'b0;
  int   exp0, exp1;
  always @(negedge clk) begin
    if (cp0) begin
      exp0 = (q0.size() != 0) ? q0.pop_front() : -1;
      chk("dut0 C_pulse cycle", cyc, exp0);
      chk("dut0 tick with C_pulse", tick0, 1);
      chk("dut0 C with C_pulse", c0, 1);
    end
    if (cp1) begin
      exp1 = (q1.size() != 0) ? q1.pop_front() : -1;
      chk("dut1 C_pulse cycle", cyc, exp1);
    end
    chk("dut0 strobe repeat", {tick0 & tick0_prev, cp0 & cp0_prev}, 0);
    chk("dut1 strobe repeat", {tick1 & tick1_prev, cp1 & cp1_prev}, 0);
    chk("dut1 C equals C_pulse", c1, cp1);
    tick0_prev = tick0;
    cp0_prev   = cp0;
    tick1_prev = tick1;
    cp1_prev   = cp1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    rst0 = 1'b1; m0 = 3'd0; pause0 = 1'b0; restart0 = 1'b0;
    rst1 = 1'b1; m1 = 3'd0; pause1 = 1'b0; restart1 = 1'b0;

    // Reset state
    cycles(1);
    chk("reset C", c0, 0);
    chk("reset C_pulse", cp0, 0);
    chk("reset tick", tick0, 0);
    chk("reset running", run0, 0);
    chk("reset secs_left", secs0, 3);

    // Basic expiry
    rst0 = 1'b0;
    e = cyc + 1;
    q0.push_back(e + 12);
    cycles(1);
    chk("basic running", run0, 1);
    chk("basic secs start", secs0, 3);
    cycles(4);
    chk("basic first tick", tick0, 1);
    chk("basic secs 2", secs0, 2);
    cycles(1);
    chk("basic tick low", tick0, 0);
    cycles(3);
    chk("basic second tick", tick0, 1);
    chk("basic secs 1", secs0, 1);
    cycles(4);
    chk("basic C rises", c0, 1);
    chk("basic secs 0", secs0, 0);
    chk("basic not running", run0, 0);
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      chk("basic C held", c0, 1);
      chk("basic secs held", secs0, 0);
    end

    // Inactive mode
    m0 = 3'd1;
    for (int i = 0; i < 30; i++) begin
      cycles(1);
      chk("inactive running", run0, 0);
      chk("inactive secs", secs0, 3);
      chk("inactive tick", tick0, 0);
      chk("inactive C", c0, 0);
    end
    m0 = 3'd5;
    e = cyc + 1;
    q0.push_back(e + 12);
    cycles(1);
    chk("mode5 running", run0, 1);
    cycles(12);
    chk("mode5 C", c0, 1);
    m0 = 3'd1;
    cycles(2);

    // Pause for 5 cycles at secs_left=2
    m0 = 3'd0;
    e = cyc + 1;
    q0.push_back(e + 17);
    cycles(5);
    chk("pause pre secs", secs0, 2);
    cycles(1);
    pause0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      chk("pause secs frozen", secs0, 2);
      chk("pause no tick", tick0, 0);
    end
    chk("pause not running", run0, 0);
    pause0 = 1'b0;
    cycles(1);
    chk("pause resumed running", run0, 1);
    cycles(6);
    chk("pause delayed C", c0, 1);
    m0 = 3'd1;
    cycles(2);

    // Active-to-active mode switch mid-run, then inactive while expired
    m0 = 3'd0;
    e = cyc + 1;
    q0.push_back(e + 12);
    cycles(6);
    m0 = 3'd2;
    cycles(7);
    chk("switch C", c0, 1);
    cycles(3);
    m0 = 3'd3;
    cycles(1);
    chk("expired->idle C", c0, 0);
    chk("expired->idle secs", secs0, 3);
    chk("expired->idle running", run0, 0);
    cycles(1);

    // Restart on the same edge as the final wrap
    m0 = 3'd0;
    e = cyc + 1;
    cycles(12);
    restart0 = 1'b1;
    q0.push_back(e + 24);
    cycles(1);
    restart0 = 1'b0;
    chk("restart no C_pulse", cp0, 0);
    chk("restart C", c0, 0);
    chk("restart secs", secs0, 3);
    chk("restart no tick", tick0, 0);
    chk("restart running", run0, 1);
    cycles(12);
    chk("restart late C", c0, 1);
    chk("restart late secs", secs0, 0);

    // Auto-reload: four periods
    rst1 = 1'b0;
    e = cyc + 1;
    for (int k = 1; k <= 4; k++) q1.push_back(e + 12 * k);
    cycles(1);
    chk("reload running", run1, 1);
    cycles(12);
    chk("reload C_pulse 1", cp1, 1);
    chk("reload secs reloaded", secs1, 3);
    chk("reload stays running", run1, 1);
    cycles(1);
    chk("reload C drops", c1, 0);
    cycles(11);
    chk("reload C_pulse 2", cp1, 1);
    cycles(12);
    chk("reload C_pulse 3", cp1, 1);
    cycles(12);
    chk("reload C_pulse 4", cp1, 1);
    cycles(4);
    chk("reload tick before reset", tick1, 1);
    chk("reload secs before reset", secs1, 2);

    // Asynchronous reset between edges
    #2 rst1 = 1'b1;
    #1;
    chk("async C", c1, 0);
    chk("async C_pulse", cp1, 0);
    chk("async tick", tick1, 0);
    chk("async running", run1, 0);
    chk("async secs", secs1, 3);
    cycles(3);
    chk("async held running", run1, 0);

    chk("dut0 pending pulses", q0.size(), 0);
    chk("dut1 pending pulses", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
